// File: rtl/nfi_engine.sv
// Game of Life next-field-iteration engine: double-buffered toroidal field,
// one row of B3/S23 updates per clock, with an edit port and a registered read port.
module nfi_engine #(
   parameter int FIELD_W  = 16,
   parameter int FIELD_H  = 16,
   parameter int GEN_BITS = 16,
   localparam int XW = (FIELD_W > 2) ? $clog2(FIELD_W) : 1,
   localparam int YW = (FIELD_H > 2) ? $clog2(FIELD_H) : 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                i_go,
   output logic                o_NFI_allowed,
   output logic                o_done,
   output logic [GEN_BITS-1:0] o_gen,
   input  logic                i_clear,
   input  logic                i_wr_en,
   input  logic [XW-1:0]       i_wr_x,
   input  logic [YW-1:0]       i_wr_y,
   input  logic                i_wr_val,
   input  logic [XW-1:0]       i_rd_x,
   input  logic [YW-1:0]       i_rd_y,
   output logic                o_rd_cell
);

   typedef enum logic [1:0] {IDLE, CALC, SWAP} state_t;

   localparam logic [XW:0]   X_LIM  = (XW+1)'(FIELD_W);
   localparam logic [YW:0]   Y_LIM  = (YW+1)'(FIELD_H);
   localparam logic [YW-1:0] H_LAST = YW'(FIELD_H - 1);

   state_t               state_q, state_d;
   logic [YW-1:0]        row;
   logic                 front_sel;
   logic [GEN_BITS-1:0]  gen;
   logic                 rd_cell;

   logic [FIELD_W-1:0]   fld_a [FIELD_H];
   logic [FIELD_W-1:0]   fld_b [FIELD_H];

   logic                 row_last;
   logic [YW-1:0]        row_up, row_dn;
   logic [FIELD_W-1:0]   up_row, mid_row, dn_row, next_row;
   logic                 wr_in_range, rd_in_range;

   // Full B3/S23 update of one row; columns wrap around the torus.
   function automatic logic [FIELD_W-1:0] life_row(input logic [FIELD_W-1:0] up,
                                                    input logic [FIELD_W-1:0] mid,
                                                    input logic [FIELD_W-1:0] dn);
      logic [FIELD_W-1:0] res;
      logic [3:0]         n;
      int                 cl, cr;
      res = '0;
      for (int c = 0; c < FIELD_W; c++) begin
         cl = (c == 0) ? FIELD_W - 1 : c - 1;
         cr = (c == FIELD_W - 1) ? 0 : c + 1;
         n  = 4'(up[cl]) + 4'(up[c]) + 4'(up[cr])
            + 4'(mid[cl])            + 4'(mid[cr])
            + 4'(dn[cl]) + 4'(dn[c]) + 4'(dn[cr]);
         res[c] = (n == 4'd3) | (mid[c] & (n == 4'd2));
      end
      return res;
   endfunction

   assign row_last    = (row == H_LAST);
   assign row_up      = (row == '0) ? H_LAST : row - 1'b1;
   assign row_dn      = row_last ? '0 : row + 1'b1;
   assign wr_in_range = ({1'b0, i_wr_x} < X_LIM) && ({1'b0, i_wr_y} < Y_LIM);
   assign rd_in_range = ({1'b0, i_rd_x} < X_LIM) && ({1'b0, i_rd_y} < Y_LIM);

   always_comb begin
      up_row  = fld_a[row_up];
      mid_row = fld_a[row];
      dn_row  = fld_a[row_dn];
      if (front_sel) begin
         up_row  = fld_b[row_up];
         mid_row = fld_b[row];
         dn_row  = fld_b[row_dn];
      end
   end

   assign next_row = life_row(up_row, mid_row, dn_row);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d       = state_q;
      o_done        = 1'b0;
      o_NFI_allowed = 1'b0;
      case (state_q)
         IDLE: begin
            o_NFI_allowed = 1'b1;
            if (i_go) state_d = CALC;
         end
         CALC: if (row_last) state_d = SWAP;
         SWAP: begin
            o_done  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         row       <= '0;
         front_sel <= 1'b0;
         gen       <= '0;
      end else begin
         if (state_q == IDLE)                 row <= '0;
         else if (state_q == CALC && !row_last) row <= row + 1'b1;
         if (state_q == SWAP) begin
            front_sel <= ~front_sel;
            gen       <= gen + 1'b1;
         end
      end
   end

   // Edits touch only the front buffer in IDLE; CALC writes only the back buffer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int r = 0; r < FIELD_H; r++) begin
            fld_a[r] <= '0;
            fld_b[r] <= '0;
         end
      end else if (state_q == IDLE) begin
         if (i_clear) begin
            for (int r = 0; r < FIELD_H; r++) begin
               if (front_sel) fld_b[r] <= '0;
               else           fld_a[r] <= '0;
            end
         end else if (i_wr_en && wr_in_range) begin
            if (front_sel) fld_b[i_wr_y][i_wr_x] <= i_wr_val;
            else           fld_a[i_wr_y][i_wr_x] <= i_wr_val;
         end
      end else if (state_q == CALC) begin
         if (front_sel) fld_a[row] <= next_row;
         else           fld_b[row] <= next_row;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)            rd_cell <= 1'b0;
      else if (!rd_in_range) rd_cell <= 1'b0;
      else if (front_sel)    rd_cell <= fld_b[i_rd_y][i_rd_x];
      else                   rd_cell <= fld_a[i_rd_y][i_rd_x];
   end

   assign o_gen     = gen;
   assign o_rd_cell = rd_cell;

endmodule

// File: tb/tb_nfi_engine.sv
// Scoreboard bench for nfi_engine: directed Life patterns with hand-derived
// expected fields and generation counts, checked by a separate monitor.
module tb_nfi_engine;
   localparam int FW = 16;
   localparam int FH = 16;
   localparam int GB = 16;

   logic          clk, rst_n;
   logic          i_go, o_NFI_allowed, o_done, o_rd_cell;
   logic [GB-1:0] o_gen;
   logic          i_clear, i_wr_en, i_wr_val;
   logic [3:0]    i_wr_x, i_wr_y, i_rd_x, i_rd_y;

   logic          rd_req, rd_pend;
   int            checks, failures;
   int            gen_m;
   logic [FW-1:0] exp_fld [FH];
   int            exp_rd_q [$];
   int            exp_gen_q [$];

   nfi_engine #(.FIELD_W(FW), .FIELD_H(FH), .GEN_BITS(GB)) dut (
      .clk(clk), .rst_n(rst_n), .i_go(i_go), .o_NFI_allowed(o_NFI_allowed),
      .o_done(o_done), .o_gen(o_gen), .i_clear(i_clear), .i_wr_en(i_wr_en),
      .i_wr_x(i_wr_x), .i_wr_y(i_wr_y), .i_wr_val(i_wr_val),
      .i_rd_x(i_rd_x), .i_rd_y(i_rd_y), .o_rd_cell(o_rd_cell)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) rd_pend <= rd_req;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: read data arrives the cycle after a request, o_gen the cycle after o_done.
   initial begin : monitor
      logic gen_pend;
      int   e;
      gen_pend = 1'b0;
      forever begin
         @(negedge clk);
         if (rd_pend) begin
            if (exp_rd_q.size() == 0) chk("rd_unexpected", 1, 0);
            else begin
               e = exp_rd_q.pop_front();
               chk("rd_cell", int'(o_rd_cell), e);
            end
         end
         if (gen_pend) begin
            if (exp_gen_q.size() == 0) chk("done_unexpected", 1, 0);
            else begin
               e = exp_gen_q.pop_front();
               chk("gen_after_done", int'(o_gen), e);
            end
         end
         gen_pend = o_done;
      end
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic exp_clear();
      for (int r = 0; r < FH; r++) exp_fld[r] = '0;
   endtask

   task automatic wr_cell(input int x, input int y, input logic v);
      i_wr_en = 1'b1; i_wr_x = 4'(x); i_wr_y = 4'(y); i_wr_val = v;
      tick();
      i_wr_en = 1'b0;
      exp_fld[y][x] = v;
   endtask

   task automatic clear_field();
      i_clear = 1'b1;
      tick();
      i_clear = 1'b0;
      exp_clear();
   endtask

   task automatic check_field();
      for (int y = 0; y < FH; y++)
         for (int x = 0; x < FW; x++) begin
            i_rd_x = 4'(x); i_rd_y = 4'(y); rd_req = 1'b1;
            exp_rd_q.push_back(int'(exp_fld[y][x]));
            tick();
         end
      rd_req = 1'b0;
      tick(); tick();
   endtask

   // One iteration; optionally hammers the edit port for the whole busy period.
   task automatic run_gen(input bit busy_edit);
      bit idle;
      gen_m++;
      exp_gen_q.push_back(gen_m & 16'hFFFF);
      i_go = 1'b1;
      tick();
      i_go = 1'b0;
      idle = 1'b0;
      for (int i = 0; i < 64 && !idle; i++) begin
         if (o_NFI_allowed) idle = 1'b1;
         else begin
            if (busy_edit) begin
               i_wr_en = 1'b1; i_wr_x = 4'd8; i_wr_y = 4'd8; i_wr_val = 1'b1;
               i_clear = i[0];
            end
            tick();
         end
      end
      i_wr_en = 1'b0; i_clear = 1'b0;
      if (!idle) chk("iteration_timeout", 0, 1);
   endtask

   initial begin
      rst_n = 1'b0; i_go = 1'b0; i_clear = 1'b0; i_wr_en = 1'b0; i_wr_val = 1'b0;
      i_wr_x = '0; i_wr_y = '0; i_rd_x = '0; i_rd_y = '0; rd_req = 1'b0;
      checks = 0; failures = 0; gen_m = 0;
      exp_clear();
      repeat (2) tick();
      rst_n = 1'b1;
      chk("rst_allowed", int'(o_NFI_allowed), 1);
      chk("rst_done", int'(o_done), 0);
      chk("rst_gen", int'(o_gen), 0);
      chk("rst_rd_cell", int'(o_rd_cell), 0);
      tick();

      // Blinker, second generation run with edits attempted while busy
      wr_cell(1, 0, 1'b1); wr_cell(1, 1, 1'b1); wr_cell(1, 2, 1'b1);
      check_field();
      run_gen(1'b0);
      exp_clear(); exp_fld[1][0] = 1'b1; exp_fld[1][1] = 1'b1; exp_fld[1][2] = 1'b1;
      check_field();
      chk("blinker_gen1", int'(o_gen), 1);
      run_gen(1'b1);
      exp_clear(); exp_fld[0][1] = 1'b1; exp_fld[1][1] = 1'b1; exp_fld[2][1] = 1'b1;
      check_field();
      chk("blinker_gen2", int'(o_gen), 2);

      // Timing: busy for FH+1 cycles, single o_done, mid-run go ignored
      gen_m++;
      exp_gen_q.push_back(gen_m);
      i_go = 1'b1;
      tick();
      i_go = 1'b0;
      for (int i = 1; i <= FH + 2; i++) begin
         chk($sformatf("allowed_c%0d", i), int'(o_NFI_allowed), (i <= FH + 1) ? 0 : 1);
         chk($sformatf("done_c%0d", i), int'(o_done), (i == FH + 1) ? 1 : 0);
         i_go = (i == 5);
         if (i < FH + 2) tick();
      end
      i_go = 1'b0;
      tick();
      exp_clear(); exp_fld[1][0] = 1'b1; exp_fld[1][1] = 1'b1; exp_fld[1][2] = 1'b1;
      check_field();
      chk("timing_gen", int'(o_gen), 3);

      // Clear, then empty field stays empty
      clear_field();
      check_field();
      run_gen(1'b0);
      check_field();

      // 2x2 block is a still life
      wr_cell(7, 7, 1'b1); wr_cell(8, 7, 1'b1); wr_cell(7, 8, 1'b1); wr_cell(8, 8, 1'b1);
      repeat (5) run_gen(1'b0);
      check_field();
      chk("block_gen", int'(o_gen), 9);

      // Write on the same edge as go is part of the computed generation
      clear_field();
      wr_cell(5, 5, 1'b1); wr_cell(6, 5, 1'b1);
      gen_m++;
      exp_gen_q.push_back(gen_m);
      i_wr_en = 1'b1; i_wr_x = 4'd7; i_wr_y = 4'd5; i_wr_val = 1'b1; i_go = 1'b1;
      tick();
      i_wr_en = 1'b0; i_go = 1'b0;
      for (int i = 0; i < 64 && !o_NFI_allowed; i++) tick();
      exp_clear(); exp_fld[4][6] = 1'b1; exp_fld[5][6] = 1'b1; exp_fld[6][6] = 1'b1;
      check_field();

      // Glider across both wrap edges returns home after 64 generations
      clear_field();
      wr_cell(15, 14, 1'b1); wr_cell(0, 15, 1'b1); wr_cell(14, 0, 1'b1);
      wr_cell(15, 0, 1'b1); wr_cell(0, 0, 1'b1);
      repeat (64) run_gen(1'b0);
      check_field();
      chk("glider_gen", int'(o_gen), 74);

      // Reset while computing row 7
      i_go = 1'b1;
      tick();
      i_go = 1'b0;
      repeat (7) tick();
      chk("midcalc_busy", int'(o_NFI_allowed), 0);
      rst_n = 1'b0;
      #1;
      chk("midrst_allowed", int'(o_NFI_allowed), 1);
      chk("midrst_gen", int'(o_gen), 0);
      chk("midrst_done", int'(o_done), 0);
      tick();
      rst_n = 1'b1;
      gen_m = 0;
      exp_clear();
      check_field();
      chk("midrst_gen_after", int'(o_gen), 0);

      repeat (3) tick();
      chk("rd_queue_drained", exp_rd_q.size(), 0);
      chk("gen_queue_drained", exp_gen_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end
endmodule
